// File: rtl/cpu_dma_pkg.sv
// Shared types and constants for the cycle-stealing DMA sequencer.
package cpu_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT,
        ST_ALIGN,
        ST_READ,
        ST_WRITE
    } dma_state_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // Channel index width; a single channel still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cpu_dma_prio_arb.sv
// Combinational fixed-priority arbiter: lowest set bit of i_pend wins.
module cpu_dma_prio_arb #(
    parameter int NUM_CH = 2,
    parameter int IDX_W  = 1
) (
    input  logic [NUM_CH-1:0] i_pend,
    output logic [NUM_CH-1:0] o_grant,
    output logic [IDX_W-1:0]  o_idx,
    output logic              o_any
);

    // w_lower[k] is set when any channel below k is pending.
    logic [NUM_CH-1:0] w_lower;

    assign w_lower[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < NUM_CH; gi++) begin : g_lower
            assign w_lower[gi] = w_lower[gi-1] | i_pend[gi-1];
        end
        for (gi = 0; gi < NUM_CH; gi++) begin : g_grant
            assign o_grant[gi] = i_pend[gi] & ~w_lower[gi];
        end
    endgenerate

    always_comb begin
        o_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (i_pend[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

    assign o_any = |i_pend;

endmodule

// File: rtl/cpu_dma_seq.sv
// Multi-channel DMA sequencer: halts the CPU, copies source byte blocks to a
// fixed destination port on get/put parity, and chains pending channels.
module cpu_dma_seq
    import cpu_dma_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 8
) (
    input  logic                     DMA_phi2,
    input  logic                     DMA_RST,
    input  logic [NUM_CH-1:0]        DMA_req,
    input  logic [NUM_CH*ADDR_W-1:0] DMA_src,
    input  logic [NUM_CH*ADDR_W-1:0] DMA_dst,
    input  logic [NUM_CH*LEN_W-1:0]  DMA_len,
    input  logic                     CPU_rdy,
    input  logic [7:0]               DMA_din,
    output logic                     DMA_halt,
    output logic                     DMA_bus_en,
    output logic [ADDR_W-1:0]        DMA_addr,
    output logic                     DMA_rw,
    output logic [7:0]               DMA_dout,
    output logic [NUM_CH-1:0]        DMA_ack
);

    localparam int IDX_W = idx_width(NUM_CH);

    dma_state_t          r_state, w_state_next;
    logic                r_p;
    logic [NUM_CH-1:0]   r_pend;
    logic [NUM_CH-1:0]   r_sel, w_sel_next;
    logic [ADDR_W-1:0]   r_src_cur, w_src_next;
    logic [ADDR_W-1:0]   r_dst, w_dst_next;
    logic [LEN_W-1:0]    r_cnt, w_cnt_next;
    logic [7:0]          r_data, w_data_next;

    logic                w_last;
    logic [NUM_CH-1:0]   w_ack;
    logic [NUM_CH-1:0]   w_arb_pend;
    logic [NUM_CH-1:0]   w_grant;
    logic [IDX_W-1:0]    w_grant_idx;
    logic                w_any;
    logic [ADDR_W-1:0]   w_load_src;
    logic [ADDR_W-1:0]   w_load_dst;
    logic [LEN_W-1:0]    w_load_len;

    assign w_last = (r_state == ST_WRITE) && (r_cnt == LEN_W'(1));
    assign w_ack  = w_last ? r_sel : '0;

    // The finishing channel is masked so a chain point only sees other channels.
    assign w_arb_pend = r_pend & ~w_ack;

    cpu_dma_prio_arb #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_arb (
        .i_pend  (w_arb_pend),
        .o_grant (w_grant),
        .o_idx   (w_grant_idx),
        .o_any   (w_any)
    );

    assign w_load_src = DMA_src[w_grant_idx*ADDR_W +: ADDR_W];
    assign w_load_dst = DMA_dst[w_grant_idx*ADDR_W +: ADDR_W];
    assign w_load_len = DMA_len[w_grant_idx*LEN_W +: LEN_W];

    always_ff @(posedge DMA_phi2) begin
        if (DMA_RST) begin
            r_state   <= ST_IDLE;
            r_p       <= 1'b0;
            r_pend    <= '0;
            r_sel     <= '0;
            r_src_cur <= '0;
            r_dst     <= '0;
            r_cnt     <= '0;
            r_data    <= '0;
        end else begin
            r_state   <= w_state_next;
            r_p       <= ~r_p;
            r_pend    <= (r_pend & ~w_ack) | DMA_req;
            r_sel     <= w_sel_next;
            r_src_cur <= w_src_next;
            r_dst     <= w_dst_next;
            r_cnt     <= w_cnt_next;
            r_data    <= w_data_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_sel_next   = r_sel;
        w_src_next   = r_src_cur;
        w_dst_next   = r_dst;
        w_cnt_next   = r_cnt;
        w_data_next  = r_data;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_next = ST_HALT;
                    w_sel_next   = w_grant;
                    w_src_next   = w_load_src;
                    w_dst_next   = w_load_dst;
                    w_cnt_next   = w_load_len;
                end
            end
            ST_HALT: begin
                // A read must land on p=0, so an even-parity grant burns one cycle.
                if (CPU_rdy) begin
                    w_state_next = r_p ? ST_READ : ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                w_state_next = ST_READ;
            end
            ST_READ: begin
                w_data_next  = DMA_din;
                w_state_next = ST_WRITE;
            end
            ST_WRITE: begin
                w_src_next = r_src_cur + ADDR_W'(1);
                w_cnt_next = r_cnt - LEN_W'(1);
                if (!w_last) begin
                    w_state_next = ST_READ;
                end else if (w_any) begin
                    w_state_next = ST_READ;
                    w_sel_next   = w_grant;
                    w_src_next   = w_load_src;
                    w_dst_next   = w_load_dst;
                    w_cnt_next   = w_load_len;
                end else begin
                    w_state_next = ST_IDLE;
                    w_sel_next   = '0;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        DMA_halt   = (r_state != ST_IDLE);
        DMA_bus_en = (r_state == ST_READ) || (r_state == ST_WRITE);
        DMA_addr   = '0;
        DMA_rw     = RW_READ;
        DMA_dout   = '0;
        if (r_state == ST_READ) begin
            DMA_addr = r_src_cur;
        end else if (r_state == ST_WRITE) begin
            DMA_addr = r_dst;
            DMA_rw   = RW_WRITE;
            DMA_dout = r_data;
        end
    end

    assign DMA_ack = w_ack;

endmodule

// File: tb/tb_cpu_dma_seq.sv
// Scoreboard bench for cpu_dma_seq: expected bus reads/writes are queued at
// request time and compared as the DMA drives the bus.
module tb_cpu_dma_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
    logic        rdy;
    logic [7:0]  din;
    logic        halt;
    logic        bus_en;
    logic [15:0] addr;
    logic        rw;
    logic [7:0]  dout;
    logic [1:0]  ack;

    always #5 clk = ~clk;

    cpu_dma_seq #(.NUM_CH(2), .ADDR_W(16), .LEN_W(8)) dut (
        .DMA_phi2   (clk),
        .DMA_RST    (rst),
        .DMA_req    (req),
        .DMA_src    (src),
        .DMA_dst    (dst),
        .DMA_len    (len),
        .CPU_rdy    (rdy),
        .DMA_din    (din),
        .DMA_halt   (halt),
        .DMA_bus_en (bus_en),
        .DMA_addr   (addr),
        .DMA_rw     (rw),
        .DMA_dout   (dout),
        .DMA_ack    (ack)
    );

    function automatic logic [7:0] mem(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
    endfunction

    assign din = mem(addr);

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    logic        tb_p     = 1'b0;
    logic [15:0] rd_q[$];
    logic [23:0] wr_q[$];
    int          halt_cnt = 0;
    int          wr_seen  = 0;
    int          ack_cnt[2];
    int          ack_cyc[2];

    // Bench model of the free-running get/put parity.
    always @(posedge clk) begin
        cyc  <= cyc + 1;
        tb_p <= rst ? 1'b0 : ~tb_p;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (halt) halt_cnt++;
            for (int c = 0; c < 2; c++) begin
                if (ack[c]) begin
                    ack_cnt[c]++;
                    ack_cyc[c] = cyc;
                end
            end
            if (bus_en && rw) begin
                n_checks++;
                if (rd_q.size() == 0) begin
                    $display("FAIL rd_unexpected got addr=%h want none", addr);
                end else begin
                    logic [15:0] e;
                    e = rd_q.pop_front();
                    if (addr !== e) $display("FAIL rd_addr got %h want %h", addr, e);
                    else n_pass++;
                end
            end
            if (bus_en && !rw) begin
                wr_seen++;
                n_checks++;
                if (wr_q.size() == 0) begin
                    $display("FAIL wr_unexpected got %h/%h want none", addr, dout);
                end else begin
                    logic [23:0] e;
                    e = wr_q.pop_front();
                    if ({addr, dout} !== e) $display("FAIL wr got %h/%h want %h/%h", addr, dout, e[23:8], e[7:0]);
                    else n_pass++;
                end
            end
        end
    end

    task automatic set_ch(input int ch, input logic [15:0] s, input logic [15:0] d, input logic [7:0] l);
        src[ch*16 +: 16] = s;
        dst[ch*16 +: 16] = d;
        len[ch*8 +: 8]   = l;
    endtask

    task automatic push_xfer(input logic [15:0] s, input logic [15:0] d, input logic [7:0] l);
        int n;
        logic [15:0] a;
        n = (l == 8'd0) ? 256 : int'(l);
        for (int i = 0; i < n; i++) begin
            a = s + 16'(i);
            rd_q.push_back(a);
            wr_q.push_back({d, mem(a)});
        end
    endtask

    task automatic clear_mon();
        @(posedge clk);
        halt_cnt   = 0;
        wr_seen    = 0;
        ack_cnt[0] = 0;
        ack_cnt[1] = 0;
        ack_cyc[0] = 0;
        ack_cyc[1] = 0;
    endtask

    task automatic pulse_req(input logic [1:0] mask, input logic want_p);
        @(negedge clk);
        while (tb_p !== want_p) @(negedge clk);
        req = mask;
        @(negedge clk);
        req = 2'b00;
    endtask

    task automatic wait_halt(input logic val, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (halt === val) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({halt, bus_en, addr, rw, dout, ack} !== {1'b0, 1'b0, 16'h0, 1'b1, 8'h0, 2'b00})
            $display("FAIL reset_outputs got %b%b %h %b %h %b want 00 0000 1 00 00", halt, bus_en, addr, rw, dout, ack);
        else n_pass++;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (halt !== 1'b0) $display("FAIL idle_no_halt got %b want 0", halt);
        else n_pass++;
    endtask

    task automatic test_basic(input logic want_p, input int exp_halt);
        bit ok;
        set_ch(0, 16'h0200, 16'h2004, 8'd4);
        push_xfer(16'h0200, 16'h2004, 8'd4);
        clear_mon();
        pulse_req(2'b01, want_p);
        wait_halt(1'b1, 10, ok);
        wait_halt(1'b0, 100, ok);
        n_checks++;
        if (!ok) $display("FAIL basic_timeout got busy want idle");
        else n_pass++;
        n_checks++;
        if (halt_cnt != exp_halt) $display("FAIL basic_halt_len got %0d want %0d", halt_cnt, exp_halt);
        else n_pass++;
        n_checks++;
        if (ack_cnt[0] != 1 || ack_cnt[1] != 0) $display("FAIL basic_acks got %0d/%0d want 1/0", ack_cnt[0], ack_cnt[1]);
        else n_pass++;
        n_checks++;
        if (wr_q.size() != 0 || rd_q.size() != 0) $display("FAIL basic_left got %0d/%0d want 0/0", rd_q.size(), wr_q.size());
        else n_pass++;
    endtask

    task automatic test_len0();
        bit ok;
        set_ch(0, 16'h1000, 16'h2004, 8'd0);
        push_xfer(16'h1000, 16'h2004, 8'd0);
        clear_mon();
        pulse_req(2'b01, 1'b1);
        wait_halt(1'b1, 10, ok);
        wait_halt(1'b0, 1000, ok);
        n_checks++;
        if (!ok) $display("FAIL len0_timeout got busy want idle");
        else n_pass++;
        n_checks++;
        if (halt_cnt != 513) $display("FAIL len0_halt_len got %0d want 513", halt_cnt);
        else n_pass++;
        n_checks++;
        if (wr_seen != 256 || ack_cnt[0] != 1) $display("FAIL len0_writes got %0d w %0d ack want 256 w 1 ack", wr_seen, ack_cnt[0]);
        else n_pass++;
    endtask

    task automatic test_rdy_stall();
        bit ok;
        set_ch(0, 16'h0600, 16'h2004, 8'd4);
        push_xfer(16'h0600, 16'h2004, 8'd4);
        rdy = 1'b0;
        clear_mon();
        pulse_req(2'b01, 1'b0);
        wait_halt(1'b1, 10, ok);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (bus_en !== 1'b0 || halt !== 1'b1) $display("FAIL stall_hold got halt=%b bus_en=%b want 1/0", halt, bus_en);
            else n_pass++;
            @(negedge clk);
        end
        rdy = 1'b1;
        wait_halt(1'b0, 100, ok);
        n_checks++;
        if (halt_cnt != 12) $display("FAIL stall_halt_len got %0d want 12", halt_cnt);
        else n_pass++;
        n_checks++;
        if (ack_cnt[0] != 1) $display("FAIL stall_ack got %0d want 1", ack_cnt[0]);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit ok;
        set_ch(0, 16'h0400, 16'h2004, 8'd2);
        set_ch(1, 16'h0500, 16'h4014, 8'd3);
        push_xfer(16'h0400, 16'h2004, 8'd2);
        push_xfer(16'h0500, 16'h4014, 8'd3);
        clear_mon();
        pulse_req(2'b11, 1'b1);
        wait_halt(1'b1, 10, ok);
        wait_halt(1'b0, 100, ok);
        n_checks++;
        if (halt_cnt != 11) $display("FAIL chain_halt_len got %0d want 11", halt_cnt);
        else n_pass++;
        n_checks++;
        if (ack_cnt[0] != 1 || ack_cnt[1] != 1) $display("FAIL chain_acks got %0d/%0d want 1/1", ack_cnt[0], ack_cnt[1]);
        else n_pass++;
        n_checks++;
        if (ack_cyc[1] - ack_cyc[0] != 6) $display("FAIL chain_ack_gap got %0d want 6", ack_cyc[1] - ack_cyc[0]);
        else n_pass++;
        n_checks++;
        if (wr_q.size() != 0) $display("FAIL chain_left got %0d want 0", wr_q.size());
        else n_pass++;
    endtask

    task automatic test_wrap_and_abort();
        bit ok;
        int acks_before;
        set_ch(0, 16'hFFFE, 16'h2004, 8'd3);
        push_xfer(16'hFFFE, 16'h2004, 8'd3);
        clear_mon();
        pulse_req(2'b01, 1'b1);
        wait_halt(1'b1, 10, ok);
        wait_halt(1'b0, 100, ok);
        n_checks++;
        if (rd_q.size() != 0 || ack_cnt[0] != 1) $display("FAIL wrap_done got %0d left %0d ack want 0 left 1 ack", rd_q.size(), ack_cnt[0]);
        else n_pass++;

        set_ch(0, 16'h0300, 16'h2004, 8'd8);
        push_xfer(16'h0300, 16'h2004, 8'd8);
        clear_mon();
        pulse_req(2'b01, 1'b1);
        for (int i = 0; i < 50 && wr_seen < 2; i++) @(negedge clk);
        n_checks++;
        if (wr_seen < 2) $display("FAIL abort_start got %0d writes want 2", wr_seen);
        else n_pass++;
        acks_before = ack_cnt[0];
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({halt, bus_en, rw, addr, ack} !== {1'b0, 1'b0, 1'b1, 16'h0, 2'b00})
            $display("FAIL abort_outputs got %b%b%b %h %b want 001 0000 00", halt, bus_en, rw, addr, ack);
        else n_pass++;
        #1 rst = 1'b0;
        rd_q.delete();
        wr_q.delete();
        repeat (12) begin
            @(negedge clk);
            n_checks++;
            if (halt !== 1'b0) $display("FAIL abort_pend_cleared got halt=%b want 0", halt);
            else n_pass++;
        end
        n_checks++;
        if (ack_cnt[0] != acks_before) $display("FAIL abort_no_ack got %0d want %0d", ack_cnt[0], acks_before);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        req = 2'b00;
        src = '0;
        dst = '0;
        len = '0;
        rdy = 1'b1;
        test_reset();
        test_basic(1'b1, 9);
        test_basic(1'b0, 10);
        test_len0();
        test_rdy_stall();
        test_back_to_back();
        test_wrap_and_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cpu_dma_seq.md
# cpu_dma_seq

Parametrised multi-channel DMA sequencer that steals CPU bus cycles to copy byte blocks from a source address range to a fixed destination port, e.g. OAM DMA to $2004. It sits beside the CU FSM. It halts the CPU through a RDY-style handshake, aligns to the get/put cycle parity, and serves channels in fixed priority. Back-to-back requests are chained without releasing the CPU.

## Interface
Parameters:
- NUM_CH, 2, number of DMA channels (≥1)
- ADDR_W, 16, bus address width
- LEN_W, 8, transfer-length field width; length 0 means 2^LEN_W bytes

Ports:
- DMA_phi2  in  1  clock; one clock, all state updates on rising edge
- DMA_RST  in  1  synchronous, active-high reset
- DMA_req  in  NUM_CH  one-cycle request pulse per channel
- DMA_src  in  NUM_CH*ADDR_W  per-channel start source address, sampled at channel load
- DMA_dst  in  NUM_CH*ADDR_W  per-channel destination address, fixed (not incremented)
- DMA_len  in  NUM_CH*LEN_W  per-channel byte count, sampled at channel load
- CPU_rdy  in  1  CPU is in a read cycle, so halting is permitted
- DMA_din  in  8  read data from bus
- DMA_halt  out  1  stall CPU
- DMA_bus_en  out  1  DMA owns address/data bus
- DMA_addr  out  ADDR_W  bus address
- DMA_rw  out  1  1=read, 0=write
- DMA_dout  out  8  write data
- DMA_ack  out  NUM_CH  one-cycle completion pulse per channel

## Operation
- Pending register `pend[NUM_CH]`:
  - set by `DMA_req[i]`; cleared by `DMA_ack[i]`.
  - Set wins on the same cycle.
  - A pulse while already pending is absorbed.
  - A pulse for the active channel re-queues it.
- Parity flop `p`: 0 after reset, toggles every cycle unconditionally. READ cycles have p=0 (get); WRITE cycles have p=1 (put).
- Arbiter: lowest pending index wins. Selection happens only on IDLE→HALT and at chain points, never mid-transfer.
- States:
  - IDLE: no bus ownership. Any pend → HALT; latch winner index, src, dst, len.
  - HALT: `DMA_halt`=1, bus not owned. Waits while CPU_rdy=0. On CPU_rdy=1: p=1 → READ; p=0 → ALIGN.
  - ALIGN: one dummy cycle with halt asserted → READ.
  - READ: addr=src_cur, rw=1; DMA_din captured into data register at cycle end → WRITE.
  - WRITE: addr=dst, rw=0, dout=data register; src_cur+1 (mod 2^ADDR_W); cnt−1 (mod 2^LEN_W).
    - cnt≠1 → READ.
    - cnt=1: pulse ack, clear pend. If another pend exists, load the new winner and go to READ (parity already correct, halt stays high). Otherwise → IDLE.
- Count: `cnt` is LEN_W bits, loaded with len, terminal at cnt=1. len=0 therefore gives 2^LEN_W bytes.
- Outputs by state (decoded from state registers only; no combinational input→output path):
  - `DMA_halt`=1 in HALT/ALIGN/READ/WRITE.
  - `DMA_bus_en`=1 in READ/WRITE.
  - Outside READ/WRITE: addr=0, rw=1, dout=0.
- Reset (any time, including mid-transfer): state IDLE, pend=0, p=0, cnt=0, data=0. Transfer is abandoned with no ack. All outputs 0 except DMA_rw=1.

## Timing
- Request pulse at cycle t → pend set at t+1 → HALT at t+2 if IDLE.
- Per channel of N bytes, with CPU_rdy=1 on first HALT cycle: 1 HALT + (0|1 ALIGN) + 2N cycles. N=256 gives 513/514 cycles.
- Each extra HALT cycle with CPU_rdy=0 adds one cycle.
- Chained channel adds exactly 2N cycles; no HALT or ALIGN.
- Ack asserted during the final WRITE cycle. DMA_halt drops the cycle after, in IDLE.

## Structure
- Package `cpu_dma_pkg` holds:
  - `dma_state_t` enum (IDLE, HALT, ALIGN, READ, WRITE)
  - read/write encoding constants for DMA_rw
- Sub-module `cpu_dma_prio_arb`: combinational fixed-priority arbiter. NUM_CH-bit pend in; one-hot grant and index out, plus `any`.
- Top holds FSM, parity, pend, src_cur/cnt/data registers, output decode.

## Test plan
- NUM_CH=1, src=16'h0200, dst=16'h2004, len=4, CPU_rdy=1, HALT entered with p=1 → reads 0200–0203, 4 writes to 2004 with matching data. Halt high for exactly 9 cycles; one ack.
- Same with HALT entered at p=0 → one ALIGN cycle; halt high for 10 cycles.
- len=0 → 256 writes; halt high 513 or 514 cycles by parity; single ack at end.
- CPU_rdy=0 for 3 HALT cycles → no bus_en until rdy; total halt length +3.
- req=2'b11 same cycle, lens 2 and 3 → ch0 first, ack[0]; ch1 starts READ next cycle with halt still high; ack[1] after 6 more cycles.
- src=16'hFFFE, len=3 → reads FFFE, FFFF, 0000. DMA_RST asserted mid-transfer → next cycle IDLE, halt=0, bus_en=0, no ack, pend cleared.
